// File: rtl/register_writeback.sv
// Two-entry in-order writeback buffer between MEM and the register file, with
// source-busy hazard flags. Define WB_FORWARD_EN to forward buffered data to decode.
module wb_slot_match (
  input  logic       vld,
  input  logic [4:0] slot_rd,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  output logic       hit_rs,
  output logic       hit_rt
);
  assign hit_rs = vld && (slot_rd == rs);
  assign hit_rt = vld && (slot_rd == rt);
endmodule

module register_writeback (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic        in_wen,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        enable_c,
  output logic [4:0]  rd,
  output logic [31:0] write_data,
  input  logic        wb_hold,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  output logic        busy_rs,
  output logic        busy_rt,
  output logic        fwd_a_hit,
  output logic        fwd_b_hit,
  output logic [31:0] fwd_a_data,
  output logic [31:0] fwd_b_data,
  output logic [7:0]  drop_cnt
);
  localparam int DEPTH = 2;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_ent_t;

  wb_ent_t [DEPTH-1:0] ent;   // ent[0] is the head, ent[1] the newer entry
  logic    [1:0]       occ;
  logic    [DEPTH-1:0] slot_vld, hit_rs, hit_rt;
  logic                push, pop, drop;
  wb_ent_t             new_ent;

  assign new_ent  = '{rd: in_rd, data: in_data};
  assign in_ready = (occ < 2'd2);
  assign push     = in_valid && in_ready && in_wen;
  assign pop      = (occ != 2'd0) && !wb_hold;
  // Indices 16..31 are not architectural registers: retire them silently.
  assign drop     = pop && ent[0].rd[4];
  assign enable_c = pop && !ent[0].rd[4];

  assign rd         = (occ != 2'd0) ? ent[0].rd   : 5'd0;
  assign write_data = (occ != 2'd0) ? ent[0].data : 32'd0;

  generate
    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
      assign slot_vld[g] = (occ > 2'(g));
      wb_slot_match u_match (
        .vld    (slot_vld[g]),
        .slot_rd(ent[g].rd),
        .rs     (rs),
        .rt     (rt),
        .hit_rs (hit_rs[g]),
        .hit_rt (hit_rt[g])
      );
    end
  endgenerate

  assign busy_rs = |hit_rs;
  assign busy_rt = |hit_rt;

`ifdef WB_FORWARD_EN
  assign fwd_a_hit = busy_rs;
  assign fwd_b_hit = busy_rt;

  // Higher slot index is newer, so a later hit overrides an earlier one.
  always_comb begin
    fwd_a_data = '0;
    fwd_b_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (hit_rs[i]) fwd_a_data = ent[i].data;
      if (hit_rt[i]) fwd_b_data = ent[i].data;
    end
  end
`else
  assign fwd_a_hit  = 1'b0;
  assign fwd_b_hit  = 1'b0;
  assign fwd_a_data = '0;
  assign fwd_b_data = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ      <= 2'd0;
      ent      <= '0;
      drop_cnt <= 8'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          ent[occ[0]] <= new_ent;
          occ         <= occ + 2'd1;
        end
        2'b01: begin
          ent[0] <= ent[1];
          occ    <= occ - 2'd1;
        end
        // Push needs occ<2 and pop needs occ>0, so both means occ==1.
        2'b11: ent[0] <= new_ent;
        default: ;
      endcase
      if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_register_writeback.sv
// Randomized and directed bench for register_writeback against a queue-based model.
module tb_register_writeback;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_wen, wb_hold;
  logic [4:0]  in_rd, rs, rt;
  logic [31:0] in_data;
  logic        in_ready, enable_c, busy_rs, busy_rt, fwd_a_hit, fwd_b_hit;
  logic [4:0]  rd;
  logic [31:0] write_data, fwd_a_data, fwd_b_data;
  logic [7:0]  drop_cnt;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t q[$];
  int   m_drop = 0;
  int   n_chk  = 0;
  int   n_fail = 0;

  register_writeback dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_wen(in_wen), .in_rd(in_rd),
    .in_data(in_data), .in_ready(in_ready), .enable_c(enable_c), .rd(rd),
    .write_data(write_data), .wb_hold(wb_hold), .rs(rs), .rt(rt), .busy_rs(busy_rs),
    .busy_rt(busy_rt), .fwd_a_hit(fwd_a_hit), .fwd_b_hit(fwd_b_hit),
    .fwd_a_data(fwd_a_data), .fwd_b_data(fwd_b_data), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic busy_of(input logic [4:0] src);
    foreach (q[i]) if (q[i].rd == src) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] newest_of(input logic [4:0] src);
    for (int i = q.size() - 1; i >= 0; i--) if (q[i].rd == src) return q[i].data;
    return 32'd0;
  endfunction

  task automatic check_all();
    logic ne;
    ne = (q.size() > 0);
    chk("in_ready",   in_ready,   q.size() < 2);
    chk("enable_c",   enable_c,   ne && !wb_hold && (q[0].rd < 16));
    chk("rd",         rd,         ne ? q[0].rd : 5'd0);
    chk("write_data", write_data, ne ? q[0].data : 32'd0);
    chk("busy_rs",    busy_rs,    busy_of(rs));
    chk("busy_rt",    busy_rt,    busy_of(rt));
    chk("drop_cnt",   drop_cnt,   m_drop);
`ifdef WB_FORWARD_EN
    chk("fwd_a_hit",  fwd_a_hit,  busy_of(rs));
    chk("fwd_b_hit",  fwd_b_hit,  busy_of(rt));
    chk("fwd_a_data", fwd_a_data, newest_of(rs));
    chk("fwd_b_data", fwd_b_data, newest_of(rt));
`else
    chk("fwd_a_hit",  fwd_a_hit,  0);
    chk("fwd_b_hit",  fwd_b_hit,  0);
    chk("fwd_a_data", fwd_a_data, 0);
    chk("fwd_b_data", fwd_b_data, 0);
`endif
  endtask

  // Model update for one rising edge, using the inputs held across it.
  task automatic step();
    int   sz;
    logic do_push;
    ent_t e;
    if (!rst_n) begin
      q.delete();
      m_drop = 0;
    end else begin
      sz      = q.size();
      do_push = in_valid && in_wen && (sz < 2);
      if (sz > 0 && !wb_hold) begin
        e = q.pop_front();
        if (e.rd >= 16 && m_drop < 255) m_drop++;
      end
      if (do_push) q.push_back('{rd: in_rd, data: in_data});
    end
  endtask

  task automatic set_in(input logic r, v, w, input logic [4:0] d_rd, input logic [31:0] d,
                        input logic h, input logic [4:0] a, b);
    rst_n = r; in_valid = v; in_wen = w; in_rd = d_rd; in_data = d;
    wb_hold = h; rs = a; rt = b;
    #1;
  endtask

  task automatic tick();
    @(negedge clk);
    check_all();
    @(posedge clk);
    step();
    #1;
  endtask

  task automatic cycle(input logic r, v, w, input logic [4:0] d_rd, input logic [31:0] d,
                       input logic h, input logic [4:0] a, b);
    set_in(r, v, w, d_rd, d, h, a, b);
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    step();
    #1;
    // Reset state
    set_in(1, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_en", enable_c, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_wd", write_data, 0);
    chk("rst_drop", drop_cnt, 0);

    // Single write, one-cycle latency
    cycle(1, 1, 1, 3, 32'h12345678, 0, 0, 0);
    set_in(1, 0, 0, 0, 0, 0, 0, 0);
    chk("lat_en", enable_c, 1);
    chk("lat_rd", rd, 3);
    chk("lat_wd", write_data, 32'h12345678);
    tick();
    chk("lat_en_after", enable_c, 0);
    chk("lat_ready_after", in_ready, 1);

    // Hold fills the buffer, then drains in order
    cycle(1, 1, 1, 5, 32'h55, 1, 0, 0);
    cycle(1, 1, 1, 6, 32'h66, 1, 0, 0);
    set_in(1, 1, 1, 9, 32'h99, 1, 5, 6);
    chk("hold_ready", in_ready, 0);
    chk("hold_busy_rs", busy_rs, 1);
    chk("hold_busy_rt", busy_rt, 1);
    chk("hold_en", enable_c, 0);
    tick();
    set_in(1, 0, 0, 0, 0, 0, 5, 6);
    chk("drain1_en", enable_c, 1);
    chk("drain1_rd", rd, 5);
    tick();
    chk("drain2_en", enable_c, 1);
    chk("drain2_rd", rd, 6);
    tick();
    chk("drain_empty", enable_c, 0);

    // Out-of-range index is dropped and counted
    cycle(1, 1, 1, 20, 32'hAA, 0, 0, 0);
    set_in(1, 0, 0, 0, 0, 0, 0, 0);
    chk("drop_no_en", enable_c, 0);
    chk("drop_before", drop_cnt, 0);
    tick();
    chk("drop_after", drop_cnt, 1);
    for (int i = 0; i < 256; i++) cycle(1, 1, 1, 20, 32'hAA, 0, 0, 0);
    idle(2);
    chk("drop_sat", drop_cnt, 255);

    // Forwarding picks the newest matching entry
    cycle(1, 1, 1, 7, 32'h1, 1, 0, 0);
    cycle(1, 1, 1, 7, 32'h2, 1, 0, 0);
    set_in(1, 0, 0, 0, 0, 1, 7, 7);
`ifdef WB_FORWARD_EN
    chk("fwd_hit", fwd_a_hit, 1);
    chk("fwd_data", fwd_a_data, 32'h2);
`else
    chk("fwd_hit", fwd_a_hit, 0);
    chk("fwd_data", fwd_a_data, 0);
`endif
    tick();

    // Reset with two items buffered discards them
    cycle(0, 1, 1, 9, 32'h9, 1, 7, 7);
    set_in(1, 0, 0, 0, 0, 0, 7, 7);
    chk("rst_mid_en", enable_c, 0);
    chk("rst_mid_ready", in_ready, 1);
    chk("rst_mid_drop", drop_cnt, 0);
    chk("rst_mid_busy", busy_rs, 0);
    idle(2);

    // Accepted with in_wen=0 is not buffered
    set_in(1, 1, 0, 2, 32'h22, 0, 2, 2);
    chk("nowen_ready", in_ready, 1);
    tick();
    set_in(1, 0, 0, 0, 0, 0, 2, 2);
    chk("nowen_en", enable_c, 0);
    chk("nowen_busy", busy_rs, 0);
    tick();

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      logic [4:0] r_rd, r_rs, r_rt;
      r_rd = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(16, 31)) : 5'($urandom_range(0, 7));
      r_rs = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(16, 31)) : 5'($urandom_range(0, 7));
      r_rt = 5'($urandom_range(0, 7));
      cycle($urandom_range(0, 63) != 0, 1'($urandom), $urandom_range(0, 3) != 0, r_rd,
            $urandom, $urandom_range(0, 2) == 0, r_rs, r_rt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/register_writeback.md
REGISTER_WRITEBACK -- requirements
Module: register_writeback

Interface
REQ-001 SHALL have clock and reset ports: clk  input  1  single clock, all state updates on rising edge; rst_n  input  1  reset, synchronous, active-low.
REQ-002 SHALL have the MEM-side inputs: in_valid  input  1  result offered; in_wen  input  1  result writes a register; in_rd  input  5  destination index; in_data  input  32  result value.
REQ-003 SHALL have in_ready  output  1  buffer can accept this cycle.
REQ-004 SHALL have the register-file write port: enable_c  output  1  write strobe; rd  output  5  write index; write_data  output  32  write value.
REQ-005 SHALL have wb_hold  input  1  suppress draining this cycle.
REQ-006 SHALL have the hazard query inputs rs and rt  input  5 each  decode-stage source indices.
REQ-007 SHALL have busy_rs and busy_rt  output  1 each  source has a pending buffered write.
REQ-008 SHALL have fwd_a_hit and fwd_b_hit  output  1 each, and fwd_a_data and fwd_b_data  output  32 each  forwarded value (see Configuration).
REQ-009 SHALL have drop_cnt  output  8  count of discarded out-of-range writes.

Function
REQ-010 SHALL hold a 2-entry in-order FIFO of {rd, data}; in_ready = (occupancy < 2); no push when full, even with a simultaneous pop.
REQ-011 SHALL accept on a rising edge with in_valid && in_ready; accepted items with in_wen=0 SHALL be discarded (not enqueued).
REQ-012 SHALL drive rd/write_data from the FIFO head when non-empty; when empty SHALL drive rd=0 and write_data=0.
REQ-013 SHALL assert enable_c = non-empty && !wb_hold && head.rd < 16; the register file captures on the falling edge inside that cycle.
REQ-014 SHALL pop the head on the rising edge ending a cycle in which the FIFO is non-empty and wb_hold=0.
REQ-015 SHALL pop a head with rd >= 16 without asserting enable_c, and SHALL increment drop_cnt, saturating at 255.
REQ-016 Latency: an item accepted at edge k into an empty FIFO SHALL present enable_c=1 during cycle k..k+1 and pop at edge k+1.
REQ-017 Simultaneous push and pop at occupancy 1 SHALL leave occupancy 1, with the new item at the head.
REQ-018 busy_rs SHALL be 1 iff any valid entry (head included) has rd == rs; busy_rt likewise for rt; purely combinational from state and inputs.
REQ-019 wb_hold held high SHALL freeze the FIFO contents; in_ready SHALL still follow occupancy.

Reset
REQ-020 SHALL, on a rising edge with rst_n=0, clear occupancy and drop_cnt; outputs then read enable_c=0, rd=0, write_data=0, in_ready=1, busy_*=0, fwd_*=0.
REQ-021 Reset mid-operation SHALL discard all buffered items with no further enable_c pulse; reset SHALL take priority over push and pop on the same edge.

Configuration
REQ-022 Macro WB_FORWARD_EN: when defined, fwd_a_hit = busy_rs and fwd_a_data = data of the newest valid entry with rd == rs (0 if none); B/rt likewise.
REQ-023 Without WB_FORWARD_EN: fwd_a_hit, fwd_b_hit, fwd_a_data and fwd_b_data SHALL be constant 0, and busy_* remain functional for stall logic.

Verification
REQ-024 Reset, then push {rd=3, data=0x12345678}, in_wen=1 -> next cycle enable_c=1, rd=3, write_data=0x12345678; the following cycle enable_c=0, in_ready=1.
REQ-025 wb_hold=1 and push rd=5 then rd=6 -> in_ready=0, busy for rs=5 and rt=6 both 1; release hold -> writes to 5 then 6 on consecutive cycles.
REQ-026 Push rd=20, data=0xAA -> no enable_c, drop_cnt 0->1; 256 such pushes -> drop_cnt stays 255.
REQ-027 With WB_FORWARD_EN, hold, push {7, 0x1} then {7, 0x2}, rs=7 -> fwd_a_hit=1, fwd_a_data=0x2; without the macro -> fwd_a_hit=0, fwd_a_data=0.
REQ-028 Two items buffered, assert rst_n=0 for one edge -> occupancy 0, no enable_c afterwards, drop_cnt=0.
REQ-029 Push with in_wen=0, rd=2 -> accepted (in_ready=1), no enable_c, busy_rs(rs=2)=0.
